dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL provide parameter DEPTH, default 2048, number of 32-bit words implemented (1..2048).
REQ-002 SHALL provide parameter WAIT_CYCLES, default 1, wait states inserted before each response (0..15).
REQ-003 SHALL provide port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset, sampled on rising clock.
REQ-005 SHALL provide port dm_re  input  1  read request from pipeline MEM stage.
REQ-006 SHALL provide port dm_we  input  1  write request from pipeline MEM stage.
REQ-007 SHALL provide port dm_addr  input  11  word address.
REQ-008 SHALL provide port dm_wdata  input  32  store data.
REQ-009 SHALL provide port dm_data  output  32  load data, registered.
REQ-010 SHALL provide port dm_ready  output  1  one-cycle completion pulse for the captured request.
REQ-011 SHALL provide port dm_busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL provide port dm_err  output  1  one-cycle error pulse, coincident with dm_ready.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; state register, wait counter, and all outputs registered.
REQ-014 In IDLE, a rising edge with dm_re|dm_we high SHALL capture dm_re, dm_we, dm_addr, and dm_wdata, and SHALL move to WAIT (WAIT_CYCLES>0) or RESP (WAIT_CYCLES=0).
REQ-015 In IDLE with no request, the FSM SHALL remain in IDLE.
REQ-016 WAIT SHALL load counter = WAIT_CYCLES-1 on entry, decrement each cycle, and go to RESP on the edge where counter = 0.
REQ-017 dm_ready SHALL be high for exactly the one cycle spent in RESP; latency from the capture edge to dm_ready high = WAIT_CYCLES+1 edges.
REQ-018 RESP SHALL return to IDLE on the next edge unconditionally; requests present in WAIT or RESP SHALL be ignored.
REQ-019 The requester SHALL hold request and operands stable until dm_ready and drop the request in the cycle after dm_ready; the block SHALL NOT re-capture on the RESP->IDLE edge.
REQ-020 Captured write: the array word at captured address SHALL be updated with captured wdata on the edge entering RESP.
REQ-021 Captured read: dm_data SHALL load the array word on the edge entering RESP and hold that value until the next read completes; writes SHALL NOT change dm_data.
REQ-022 If dm_re and dm_we are both high at capture, the block SHALL perform the write only, leave dm_data unchanged, and assert dm_err with dm_ready.
REQ-023 If captured address >= DEPTH, the block SHALL drop the write or load 32'h0 into dm_data for a read, and assert dm_err with dm_ready.
REQ-024 dm_busy SHALL be high in WAIT and RESP and low in IDLE.
REQ-025 Read-after-write to the same address on consecutive transactions SHALL return the newly written data, with no forwarding required beyond the array.

Reset
REQ-026 On reset: state SHALL be IDLE, counter = 0, dm_data = 32'h0, dm_ready = 0, dm_busy = 0, dm_err = 0.
REQ-027 Reset SHALL override any in-flight transaction; a write not yet committed (still in WAIT) SHALL be discarded.
REQ-028 Array contents SHALL NOT be cleared by reset; reset asserted on the edge that would enter RESP SHALL also suppress that write.

Verification
REQ-029 With WAIT_CYCLES=1: write 0xDEADBEEF to addr 5, then read addr 5 -> dm_ready 2 edges after each capture, dm_data = 0xDEADBEEF, dm_err = 0.
REQ-030 With WAIT_CYCLES=0: back-to-back writes to addrs 1 and 2, with the request dropped after ready -> each completes in 1 edge, dm_busy never high in consecutive IDLE cycles, and the array shows both values on readback.
REQ-031 dm_re=dm_we=1 at addr 3, wdata 0x12345678, with prior dm_data 0xAAAA0000 -> dm_err and dm_ready pulse together, dm_data stays 0xAAAA0000, and a later read of addr 3 returns 0x12345678.
REQ-032 With DEPTH=1024: read addr 1500 -> dm_data = 0, dm_err = 1; write addr 1500 then read addr 476 -> addr 476 unchanged.
REQ-033 With WAIT_CYCLES=3: write addr 7 = 0x55, reset asserted in the second WAIT cycle -> all outputs 0 the next cycle, and a read of addr 7 returns the prior value.
REQ-034 With WAIT_CYCLES=2: toggle dm_addr while busy -> the response uses the captured address only, and no extra dm_ready pulse occurs.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for a pipeline MEM stage: one transaction at a time,
// captured in IDLE, optionally delayed by WAIT_CYCLES, answered with a one-cycle RESP.
module dmem_responder #(
  parameter int DEPTH       = 2048,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dm_re,
  input  logic        dm_we,
  input  logic [10:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_data,
  output logic        dm_ready,
  output logic        dm_busy,
  output logic        dm_err
);

  localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic [3:0]  count_next;

  logic        cap_re;
  logic        cap_we;
  logic [10:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic        txn_re;
  logic        txn_we;
  logic [10:0] txn_addr;
  logic [31:0] txn_wdata;
  logic        in_range;
  logic        conflict;
  logic        commit;
  logic [IW-1:0] idx;

  // With no wait states the commit happens on the capture edge itself, so the
  // operation in flight comes straight from the ports while IDLE.
  always_comb begin
    txn_re    = cap_re;
    txn_we    = cap_we;
    txn_addr  = cap_addr;
    txn_wdata = cap_wdata;
    if (state == IDLE) begin
      txn_re    = dm_re;
      txn_we    = dm_we;
      txn_addr  = dm_addr;
      txn_wdata = dm_wdata;
    end
  end

  assign in_range = ({21'd0, txn_addr} < 32'(DEPTH));
  assign conflict = txn_re & txn_we;
  assign idx      = txn_addr[IW-1:0];

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    count_next = count;
    commit     = 1'b0;
    unique case (state)
      IDLE: begin
        if (dm_re | dm_we) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
            count_next = WAIT_LOAD;
          end else begin
            state_next = RESP;
            commit     = 1'b1;
          end
        end
      end
      WAIT: begin
        if (count == 4'd0) begin
          state_next = RESP;
          commit     = 1'b1;
        end else begin
          count_next = count - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      count     <= 4'd0;
      cap_re    <= 1'b0;
      cap_we    <= 1'b0;
      cap_addr  <= 11'd0;
      cap_wdata <= 32'h0;
      dm_data   <= 32'h0;
      dm_ready  <= 1'b0;
      dm_busy   <= 1'b0;
      dm_err    <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (state == IDLE && (dm_re | dm_we)) begin
        cap_re    <= dm_re;
        cap_we    <= dm_we;
        cap_addr  <= dm_addr;
        cap_wdata <= dm_wdata;
      end
      dm_busy  <= (state_next != IDLE);
      dm_ready <= commit;
      dm_err   <= commit & (conflict | ~in_range);
      // A simultaneous read+write is treated as write-only: dm_data keeps its value.
      if (commit && txn_re && !txn_we) begin
        dm_data <= in_range ? mem[idx] : 32'h0;
      end
    end
  end

  // NOTE: the array is deliberately not reset (contents survive reset); the
  // write is gated by reset so a reset on the commit edge discards it.
  always_ff @(posedge clock) begin
    if (!reset && commit && txn_we && in_range) begin
      mem[idx] <= txn_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: four instances with different depth and
// wait-state settings, directed scenarios plus random traffic against a timeline model.
module tb_dmem_responder;

  function automatic int wait_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    return (i == 2) ? 1024 : 2048;
  endfunction

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst   [4];
  logic        re    [4];
  logic        we    [4];
  logic [10:0] addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] data  [4];
  logic        ready [4];
  logic        busy  [4];
  logic        err   [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_responder #(
      .DEPTH      (depth_of(g)),
      .WAIT_CYCLES(wait_of(g))
    ) u_dut (
      .clock   (clock),
      .reset   (rst[g]),
      .dm_re   (re[g]),
      .dm_we   (we[g]),
      .dm_addr (addr[g]),
      .dm_wdata(wdata[g]),
      .dm_data (data[g]),
      .dm_ready(ready[g]),
      .dm_busy (busy[g]),
      .dm_err  (err[g])
    );
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Model: a transaction captured at edge n completes at edge n+W and the block is
  // idle again after edge n+W+1; completion applies the memory/data rules directly.
  int unsigned edge_n = 0;
  bit          m_valid  [4];
  bit          m_active [4];
  int unsigned m_done   [4];
  int unsigned m_idle   [4];
  bit          m_re     [4];
  bit          m_we     [4];
  logic [10:0] m_addr   [4];
  logic [31:0] m_wd     [4];
  logic [31:0] e_data   [4];
  bit          e_known  [4];
  bit          e_ready  [4];
  bit          e_busy   [4];
  bit          e_err    [4];
  logic [31:0] mmem     [4][2048];
  bit          mknown   [4][2048];

  task automatic complete(input int i);
    bit oob;
    oob        = (int'(m_addr[i]) >= depth_of(i));
    e_ready[i] = 1'b1;
    e_err[i]   = (m_re[i] && m_we[i]) || oob;
    if (m_we[i] && !oob) begin
      mmem[i][m_addr[i]]   = m_wd[i];
      mknown[i][m_addr[i]] = 1'b1;
    end
    if (m_re[i] && !m_we[i]) begin
      if (oob) begin
        e_data[i]  = 32'h0;
        e_known[i] = 1'b1;
      end else begin
        e_data[i]  = mmem[i][m_addr[i]];
        e_known[i] = mknown[i][m_addr[i]];
      end
    end
  endtask

  task automatic model_step(input int i);
    if (rst[i]) begin
      m_valid[i]  = 1'b1;
      m_active[i] = 1'b0;
      e_busy[i]   = 1'b0;
      e_ready[i]  = 1'b0;
      e_err[i]    = 1'b0;
      e_data[i]   = 32'h0;
      e_known[i]  = 1'b1;
    end else if (m_valid[i]) begin
      e_ready[i] = 1'b0;
      e_err[i]   = 1'b0;
      if (m_active[i] && edge_n == m_idle[i]) begin
        m_active[i] = 1'b0;
        e_busy[i]   = 1'b0;
      end else begin
        if (!m_active[i] && (re[i] || we[i])) begin
          m_active[i] = 1'b1;
          m_re[i]     = re[i];
          m_we[i]     = we[i];
          m_addr[i]   = addr[i];
          m_wd[i]     = wdata[i];
          m_done[i]   = edge_n + int'(wait_of(i));
          m_idle[i]   = m_done[i] + 1;
        end
        e_busy[i] = m_active[i];
        if (m_active[i] && edge_n == m_done[i]) complete(i);
      end
    end
  endtask

  initial begin : compare_proc
    forever begin
      @(posedge clock);
      edge_n++;
      for (int i = 0; i < 4; i++) model_step(i);
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
        if (m_valid[i]) begin
          check($sformatf("u%0d cyc%0d dm_busy", i, edge_n), 32'(busy[i]), 32'(e_busy[i]));
          check($sformatf("u%0d cyc%0d dm_ready", i, edge_n), 32'(ready[i]), 32'(e_ready[i]));
          check($sformatf("u%0d cyc%0d dm_err", i, edge_n), 32'(err[i]), 32'(e_err[i]));
          if (e_known[i])
            check($sformatf("u%0d cyc%0d dm_data", i, edge_n), data[i], e_data[i]);
        end
      end
    end
  end

  // Called at a negedge; holds the request until dm_ready, keeps it through the
  // RESP->IDLE edge, drops it, then leaves one idle cycle.
  task automatic txn(input int i, input bit r, input bit w, input logic [10:0] a,
                     input logic [31:0] d, input bit toggle, output int lat, output bit err_seen);
    bit got = 1'b0;
    lat      = 0;
    err_seen = 1'b0;
    re[i]    = r;
    we[i]    = w;
    addr[i]  = a;
    wdata[i] = d;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (ready[i]) begin
        got      = 1'b1;
        lat      = c + 1;
        err_seen = err[i];
      end else if (toggle) begin
        addr[i]  = 11'($urandom);
        wdata[i] = $urandom;
      end
    end
    check($sformatf("u%0d ready_seen", i), 32'(got), 32'd1);
    @(negedge clock);
    re[i] = 1'b0;
    we[i] = 1'b0;
    @(negedge clock);
  endtask

  task automatic write_expect(input int i, input logic [10:0] a, input logic [31:0] d,
                              input bit toggle);
    int lat;
    bit e;
    txn(i, 1'b0, 1'b1, a, d, toggle, lat, e);
    check($sformatf("u%0d wr@%0d latency", i, a), 32'(lat), 32'(wait_of(i) + 1));
    check($sformatf("u%0d wr@%0d dm_err", i, a), 32'(e), 32'd0);
  endtask

  task automatic read_expect(input int i, input logic [10:0] a, input logic [31:0] expv,
                             input bit toggle);
    int lat;
    bit e;
    txn(i, 1'b1, 1'b0, a, 32'h0, toggle, lat, e);
    check($sformatf("u%0d rd@%0d dm_data", i, a), data[i], expv);
    check($sformatf("u%0d rd@%0d latency", i, a), 32'(lat), 32'(wait_of(i) + 1));
    check($sformatf("u%0d rd@%0d dm_err", i, a), 32'(e), 32'd0);
  endtask

  initial begin : stimulus
    int lat;
    bit e;
    for (int i = 0; i < 4; i++) begin
      rst[i]   = 1'b1;
      re[i]    = 1'b0;
      we[i]    = 1'b0;
      addr[i]  = 11'd0;
      wdata[i] = 32'h0;
    end
    repeat (3) @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("u%0d reset dm_data", i), data[i], 32'h0);
      check($sformatf("u%0d reset dm_ready", i), 32'(ready[i]), 32'd0);
      check($sformatf("u%0d reset dm_busy", i), 32'(busy[i]), 32'd0);
      check($sformatf("u%0d reset dm_err", i), 32'(err[i]), 32'd0);
      rst[i] = 1'b0;
    end
    @(negedge clock);

    // W=1: write then read back.
    write_expect(1, 11'd5, 32'hDEADBEEF, 1'b0);
    read_expect(1, 11'd5, 32'hDEADBEEF, 1'b0);
    check("model u1 data after rd@5", e_data[1], 32'hDEADBEEF);

    // W=0: back-to-back writes, both visible on readback.
    write_expect(0, 11'd1, 32'h0A0A0001, 1'b0);
    write_expect(0, 11'd2, 32'h0B0B0002, 1'b0);
    read_expect(0, 11'd1, 32'h0A0A0001, 1'b0);
    read_expect(0, 11'd2, 32'h0B0B0002, 1'b0);

    // Read+write together: write only, dm_data kept, error flagged.
    write_expect(1, 11'd9, 32'hAAAA0000, 1'b0);
    read_expect(1, 11'd9, 32'hAAAA0000, 1'b0);
    txn(1, 1'b1, 1'b1, 11'd3, 32'h12345678, 1'b0, lat, e);
    check("u1 rw@3 dm_err", 32'(e), 32'd1);
    check("u1 rw@3 latency", 32'(lat), 32'd2);
    check("u1 rw@3 dm_data kept", data[1], 32'hAAAA0000);
    read_expect(1, 11'd3, 32'h12345678, 1'b0);

    // DEPTH=1024: out-of-range read and write.
    write_expect(2, 11'd476, 32'h00476476, 1'b0);
    read_expect(2, 11'd476, 32'h00476476, 1'b0);
    txn(2, 1'b1, 1'b0, 11'd1500, 32'h0, 1'b0, lat, e);
    check("u2 rd@1500 dm_err", 32'(e), 32'd1);
    check("u2 rd@1500 dm_data", data[2], 32'h0);
    txn(2, 1'b0, 1'b1, 11'd1500, 32'hFFFFFFFF, 1'b0, lat, e);
    check("u2 wr@1500 dm_err", 32'(e), 32'd1);
    read_expect(2, 11'd476, 32'h00476476, 1'b0);
    check("model u2 data after rd@476", e_data[2], 32'h00476476);

    // W=2: operands toggled while busy; only captured values count.
    write_expect(2, 11'd20, 32'h00C0FFEE, 1'b1);
    read_expect(2, 11'd20, 32'h00C0FFEE, 1'b1);

    // W=3: reset in the second WAIT cycle discards the pending write.
    write_expect(3, 11'd7, 32'h00000011, 1'b0);
    re[3] = 1'b0; we[3] = 1'b1; addr[3] = 11'd7; wdata[3] = 32'h55;
    @(negedge clock);
    @(negedge clock);
    rst[3] = 1'b1;
    @(negedge clock);
    check("u3 midwait reset dm_busy", 32'(busy[3]), 32'd0);
    check("u3 midwait reset dm_ready", 32'(ready[3]), 32'd0);
    check("u3 midwait reset dm_err", 32'(err[3]), 32'd0);
    check("u3 midwait reset dm_data", data[3], 32'h0);
    rst[3] = 1'b0; we[3] = 1'b0;
    @(negedge clock);
    read_expect(3, 11'd7, 32'h00000011, 1'b0);

    // W=1: reset on the edge that would commit suppresses the write.
    write_expect(1, 11'd8, 32'h00000088, 1'b0);
    re[1] = 1'b0; we[1] = 1'b1; addr[1] = 11'd8; wdata[1] = 32'h99;
    @(negedge clock);
    rst[1] = 1'b1;
    @(negedge clock);
    check("u1 commit reset dm_busy", 32'(busy[1]), 32'd0);
    rst[1] = 1'b0; we[1] = 1'b0;
    @(negedge clock);
    read_expect(1, 11'd8, 32'h00000088, 1'b0);

    // Random traffic on every instance; the compare process checks each cycle.
    for (int i = 0; i < 4; i++) begin
      for (int t = 0; t < 25; t++) begin
        int          k;
        bit          r;
        bit          w;
        logic [10:0] a;
        k = $urandom_range(0, 9);
        r = (k == 0) || (k >= 5);
        w = (k <= 4);
        a = 11'($urandom_range(0, 15));
        if (i == 2 && $urandom_range(0, 4) == 0) a = 11'(1024 + $urandom_range(0, 1023));
        txn(i, r, w, a, $urandom, (i == 2) || ($urandom_range(0, 3) == 0), lat, e);
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
